// File: rtl/exc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | exc_pkg : shared types, vector constants and decode helpers        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package exc_pkg;

  typedef enum logic [1:0] {
    EXC_IDLE    = 2'd0,
    EXC_PENDING = 2'd1,
    EXC_HANDLER = 2'd2
  } exc_state_e;

  typedef enum logic [1:0] {
    CAUSE_ILLEGAL = 2'd0,
    CAUSE_LS      = 2'd1,
    CAUSE_DIV0    = 2'd2,
    CAUSE_ADDR    = 2'd3
  } exc_cause_e;

  localparam logic [15:0] VEC_ILLEGAL = 16'h02BC;
  localparam logic [15:0] VEC_LS      = 16'h02E4;
  localparam logic [15:0] VEC_DIV0    = 16'h030C;
  localparam logic [15:0] VEC_ADDR    = 16'h0334;

  function automatic logic vec_is_valid(input logic [15:0] addr);
    return (addr == VEC_ILLEGAL) || (addr == VEC_LS) ||
           (addr == VEC_DIV0)    || (addr == VEC_ADDR);
  endfunction

  function automatic exc_cause_e vec_to_cause(input logic [15:0] addr);
    exc_cause_e c;
    case (addr)
      VEC_LS:   c = CAUSE_LS;
      VEC_DIV0: c = CAUSE_DIV0;
      VEC_ADDR: c = CAUSE_ADDR;
      default:  c = CAUSE_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_age_cmp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | inst_age_cmp : ROB-relative age comparison of two inst numbers     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module inst_age_cmp #(
  parameter int INST_W = 6
) (
  input  logic [INST_W-1:0] a,
  input  logic [INST_W-1:0] b,
  input  logic [INST_W-1:0] head,
  output logic              a_older
);

  logic [INST_W-1:0] w_a_dist;
  logic [INST_W-1:0] w_b_dist;

  // Distance from the head wraps naturally in INST_W bits.
  assign w_a_dist = a - head;
  assign w_b_dist = b - head;
  assign a_older  = (w_a_dist < w_b_dist);

endmodule
`default_nettype wire

// File: rtl/exc_commit_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | exc_commit_ctrl : precise-exception commit / eret redirect control |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module exc_commit_ctrl
  import exc_pkg::*;
#(
  parameter int INST_W = 6,
  parameter int PC_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [PC_W-1:0]   handler_address,
  input  logic [INST_W-1:0] exc_inst_num,
  input  logic              rob_head_valid,
  input  logic [INST_W-1:0] rob_head_inst_num,
  input  logic [PC_W-1:0]   rob_head_pc,
  input  logic              eret,
  output logic              flush,
  output logic              redirect_valid,
  output logic [PC_W-1:0]   redirect_pc,
  output logic [PC_W-1:0]   epc,
  output logic [1:0]        cause,
  output logic              in_handler
);

  exc_state_e        state_q, state_d;
  logic [PC_W-1:0]   pend_addr_q, pend_addr_d;
  logic [INST_W-1:0] pend_inst_q, pend_inst_d;
  exc_cause_e        pend_cause_q, pend_cause_d;
  logic              flush_q, flush_d;
  logic              redir_valid_q, redir_valid_d;
  logic [PC_W-1:0]   redir_pc_q, redir_pc_d;
  logic [PC_W-1:0]   epc_q, epc_d;
  exc_cause_e        cause_q, cause_d;

  logic              w_exc_valid;
  exc_cause_e        w_exc_cause;
  logic              w_new_older;
  logic              w_commit;

  assign w_exc_valid = vec_is_valid(16'(handler_address));
  assign w_exc_cause = vec_to_cause(16'(handler_address));
  assign w_commit    = rob_head_valid && (rob_head_inst_num == pend_inst_q);

  inst_age_cmp #(
    .INST_W (INST_W)
  ) u_age_cmp (
    .a       (exc_inst_num),
    .b       (pend_inst_q),
    .head    (rob_head_inst_num),
    .a_older (w_new_older)
  );

  always_comb begin
    state_d       = state_q;
    pend_addr_d   = pend_addr_q;
    pend_inst_d   = pend_inst_q;
    pend_cause_d  = pend_cause_q;
    flush_d       = 1'b0;
    redir_valid_d = 1'b0;
    redir_pc_d    = redir_pc_q;
    epc_d         = epc_q;
    cause_d       = cause_q;
    case (state_q)
      EXC_IDLE: begin
        if (w_exc_valid) begin
          pend_addr_d  = handler_address;
          pend_inst_d  = exc_inst_num;
          pend_cause_d = w_exc_cause;
          state_d      = EXC_PENDING;
        end
      end
      EXC_PENDING: begin
        // Commit wins over a same-cycle arrival: the flush squashes it.
        if (w_commit) begin
          flush_d       = 1'b1;
          redir_valid_d = 1'b1;
          redir_pc_d    = pend_addr_q;
          epc_d         = rob_head_pc;
          cause_d       = pend_cause_q;
          pend_addr_d   = '0;
          pend_inst_d   = '0;
          pend_cause_d  = CAUSE_ILLEGAL;
          state_d       = EXC_HANDLER;
        end else if (w_exc_valid && w_new_older) begin
          pend_addr_d  = handler_address;
          pend_inst_d  = exc_inst_num;
          pend_cause_d = w_exc_cause;
        end
      end
      EXC_HANDLER: begin
        if (eret) begin
          flush_d       = 1'b1;
          redir_valid_d = 1'b1;
          redir_pc_d    = epc_q + PC_W'(4);
          state_d       = EXC_IDLE;
        end
      end
      default: state_d = EXC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= EXC_IDLE;
      pend_addr_q   <= '0;
      pend_inst_q   <= '0;
      pend_cause_q  <= CAUSE_ILLEGAL;
      flush_q       <= 1'b0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      epc_q         <= '0;
      cause_q       <= CAUSE_ILLEGAL;
    end else begin
      state_q       <= state_d;
      pend_addr_q   <= pend_addr_d;
      pend_inst_q   <= pend_inst_d;
      pend_cause_q  <= pend_cause_d;
      flush_q       <= flush_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      epc_q         <= epc_d;
      cause_q       <= cause_d;
    end
  end

  assign flush          = flush_q;
  assign redirect_valid = redir_valid_q;
  assign redirect_pc    = redir_pc_q;
  assign epc            = epc_q;
  assign cause          = cause_q;
  assign in_handler     = (state_q == EXC_HANDLER);

endmodule
`default_nettype wire

// File: tb/tb_exc_commit_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_exc_commit_ctrl : randomized scoreboard bench for the commit ctl|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_exc_commit_ctrl;

  typedef struct {
    int pc;
    int epc;
    int cause;
  } redir_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [15:0] handler_address = '0;
  logic [5:0]  exc_inst_num = '0;
  logic        rob_head_valid = 1'b0;
  logic [5:0]  rob_head_inst_num = '0;
  logic [15:0] rob_head_pc = '0;
  logic        eret = 1'b0;
  logic        flush, redirect_valid, in_handler;
  logic [15:0] redirect_pc, epc;
  logic [1:0]  cause;

  int n_checks = 0;
  int n_errors = 0;
  redir_t exp_q[$];

  // Reference model: 0 idle, 1 pending, 2 handler.
  int m_mode = 0, m_pinst = 0, m_paddr = 0, m_pcause = 0;
  int m_epc = 0, m_cause = 0, m_rpc = 0;
  int vecs[4] = '{32'h02BC, 32'h02E4, 32'h030C, 32'h0334};

  exc_commit_ctrl #(.INST_W(6), .PC_W(16)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .handler_address   (handler_address),
    .exc_inst_num      (exc_inst_num),
    .rob_head_valid    (rob_head_valid),
    .rob_head_inst_num (rob_head_inst_num),
    .rob_head_pc       (rob_head_pc),
    .eret              (eret),
    .flush             (flush),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .epc               (epc),
    .cause             (cause),
    .in_handler        (in_handler)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int vec_index(input int ha);
    for (int i = 0; i < 4; i++) if (vecs[i] == ha) return i;
    return -1;
  endfunction

  function automatic int age(input int x, input int h);
    return (((x - h) % 64) + 64) % 64;
  endfunction

  task automatic model_step();
    int vi;
    int ha;
    vi = vec_index(int'(handler_address));
    ha = int'(handler_address);
    if (m_mode == 0) begin
      if (vi >= 0) begin
        m_pinst = int'(exc_inst_num); m_paddr = ha; m_pcause = vi; m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (rob_head_valid && int'(rob_head_inst_num) == m_pinst) begin
        m_epc = int'(rob_head_pc); m_cause = m_pcause; m_rpc = m_paddr;
        exp_q.push_back('{pc: m_paddr, epc: m_epc, cause: m_cause});
        m_mode = 2;
      end else if (vi >= 0 &&
                   age(int'(exc_inst_num), int'(rob_head_inst_num)) <
                   age(m_pinst, int'(rob_head_inst_num))) begin
        m_pinst = int'(exc_inst_num); m_paddr = ha; m_pcause = vi;
      end
    end else begin
      if (eret) begin
        m_rpc = (m_epc + 4) % 65536;
        exp_q.push_back('{pc: m_rpc, epc: m_epc, cause: m_cause});
        m_mode = 0;
      end
    end
  endtask

  task automatic drive(input int ha, input int en, input bit hv, input int hn,
                       input int hpc, input bit er);
    @(negedge clk);
    handler_address   = 16'(ha);
    exc_inst_num      = 6'(en);
    rob_head_valid    = hv;
    rob_head_inst_num = 6'(hn);
    rob_head_pc       = 16'(hpc);
    eret              = er;
    model_step();
  endtask

  task automatic idle();
    drive(0, 0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_flush"}, int'(flush), 0);
    chk({tag, "_redirect_valid"}, int'(redirect_valid), 0);
    chk({tag, "_redirect_pc"}, int'(redirect_pc), 0);
    chk({tag, "_epc"}, int'(epc), 0);
    chk({tag, "_cause"}, int'(cause), 0);
    chk({tag, "_in_handler"}, int'(in_handler), 0);
  endtask

  // Monitor: pops an expected redirect whenever the DUT presents one.
  initial begin
    redir_t e;
    forever begin
      @(posedge clk);
      #1;
      if (redirect_valid || flush) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_redirect", int'(redirect_pc), -1);
        end else begin
          e = exp_q.pop_front();
          chk("redir_flush", int'(flush), 1);
          chk("redir_valid", int'(redirect_valid), 1);
          chk("redir_pc", int'(redirect_pc), e.pc);
          chk("redir_epc", int'(epc), e.epc);
          chk("redir_cause", int'(cause), e.cause);
        end
      end
      chk("in_handler", int'(in_handler), (m_mode == 2) ? 1 : 0);
      chk("epc_hold", int'(epc), m_epc);
      chk("cause_hold", int'(cause), m_cause);
      chk("redirect_pc_hold", int'(redirect_pc), m_rpc);
    end
  end

  initial begin
    int head;
    int r;
    int ha;
    #1 reset_n = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Boundaries in IDLE: unknown vector and stray eret.
    drive(16'h1234, 3, 1'b1, 3, 16'h0010, 1'b0);
    drive(0, 0, 1'b0, 0, 0, 1'b1);
    idle();
    idle();

    // Single exception, masked injection, eret.
    drive(16'h030C, 5, 1'b0, 2, 0, 1'b0);
    drive(0, 0, 1'b1, 5, 16'h0040, 1'b0);
    idle();
    drive(16'h0334, 7, 1'b1, 7, 16'h0090, 1'b0);
    drive(0, 0, 1'b0, 0, 0, 1'b1);
    idle();
    idle();

    // Older replaces younger around head 60.
    drive(16'h02E4, 62, 1'b0, 60, 0, 1'b0);
    drive(16'h02BC, 1, 1'b0, 60, 0, 1'b0);
    drive(0, 0, 1'b1, 62, 16'h0100, 1'b0);
    drive(16'h030C, 9, 1'b0, 0, 0, 1'b1);
    idle();
    drive(16'h02E4, 62, 1'b0, 60, 0, 1'b0);
    drive(16'h02BC, 61, 1'b0, 60, 0, 1'b0);
    drive(0, 0, 1'b1, 61, 16'h0104, 1'b0);
    drive(0, 0, 1'b0, 0, 0, 1'b1);
    idle();

    // Wrap-around: head 63, inst 0 then inst 63.
    drive(16'h030C, 0, 1'b0, 63, 0, 1'b0);
    drive(16'h0334, 63, 1'b0, 63, 0, 1'b0);
    // Exception in the commit cycle is dropped.
    drive(16'h02E4, 63, 1'b1, 63, 16'hFFFC, 1'b0);
    drive(0, 0, 1'b0, 0, 0, 1'b1);
    idle();

    // Reset mid-PENDING.
    drive(16'h02E4, 20, 1'b0, 18, 0, 1'b0);
    idle();
    @(negedge clk);
    reset_n = 1'b0;
    handler_address = '0;
    m_mode = 0; m_epc = 0; m_cause = 0; m_rpc = 0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    drive(0, 0, 1'b1, 20, 16'h0200, 1'b0);
    idle();
    idle();

    // Randomized phase.
    head = 0;
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 15)      ha = vecs[$urandom_range(0, 3)];
      else if (r < 20) ha = $urandom_range(1, 65535);
      else             ha = 0;
      if ($urandom_range(0, 2) != 0) begin
        drive(ha, (head + $urandom_range(0, 6)) % 64, 1'b1, head,
              $urandom_range(0, 65535), $urandom_range(0, 9) == 0);
        head = (head + 1) % 64;
      end else begin
        drive(ha, (head + $urandom_range(0, 6)) % 64, 1'b0, head,
              $urandom_range(0, 65535), $urandom_range(0, 9) == 0);
      end
    end
    idle();
    idle();
    idle();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exc_commit_ctrl.md
# exc_commit_ctrl

Precise-exception commit controller that sits directly downstream of the interrupt vector table. It latches the registered handler address and instruction number, and keeps only the oldest outstanding exception. It waits until that instruction reaches the reorder-buffer head, then flushes the pipeline, saves the EPC, and redirects fetch to the handler. On `eret` it redirects fetch back to EPC + 4.

## Interface
- `INST_W`, 6, width of the ROB instruction number (wraps modulo 2^INST_W)
- `PC_W`, 16, width of PC, handler address and EPC
- `clk`  in  1  system clock; all state updates on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `handler_address`  in  PC_W  registered IVT output; 0 means no exception this cycle
- `exc_inst_num`  in  INST_W  instruction number paired with `handler_address`
- `rob_head_valid`  in  1  ROB head entry is valid and retiring this cycle
- `rob_head_inst_num`  in  INST_W  instruction number at the ROB head
- `rob_head_pc`  in  PC_W  PC of the ROB head instruction
- `eret`  in  1  exception-return instruction retiring (one-cycle pulse)
- `flush`  out  1  one-cycle pulse that squashes all in-flight instructions
- `redirect_valid`  out  1  one-cycle pulse; fetch loads `redirect_pc`
- `redirect_pc`  out  PC_W  fetch target
- `epc`  out  PC_W  saved PC of the faulting instruction
- `cause`  out  2  0 illegal, 1 load/store, 2 divide-by-zero, 3 address
- `in_handler`  out  1  high while the handler is executing

## Operation
- **States:** IDLE, PENDING, HANDLER.
- **Valid exception:**
  - An exception is valid only when `handler_address` is one of 0x02BC, 0x02E4, 0x030C or 0x0334.
  - These map to cause 0, 1, 2 and 3 respectively.
  - Any other nonzero value is ignored.
- **IDLE:** a valid exception captures (`handler_address`, `exc_inst_num`, cause) into the pending registers and moves to PENDING.
- **PENDING, new exception:**
  - The new exception replaces the pending one only if it is strictly older.
  - Age rule: a is older than b iff `(a - rob_head_inst_num) mod 2^INST_W < (b - rob_head_inst_num) mod 2^INST_W`.
  - An equal instruction number keeps the existing entry.
- **PENDING, commit:** when `rob_head_valid` is high and `rob_head_inst_num` equals the registered pending number:
  - Next cycle, `flush` and `redirect_valid` pulse, `redirect_pc` = pending handler address, `epc` <= `rob_head_pc`, and `cause` is updated.
  - The state moves to HANDLER.
- **HANDLER:**
  - `in_handler` is high.
  - New exceptions are dropped (no nesting).
  - `eret` produces one cycle later: `redirect_valid` = 1, `redirect_pc` = `epc` + 4 (modulo 2^PC_W), `flush` = 1; the state returns to IDLE.
- `eret` in IDLE or PENDING is ignored.
- Entering HANDLER clears the pending registers.

## Timing
- **Reset values:**
  - `flush`, `redirect_valid`, `in_handler` = 0.
  - `redirect_pc`, `epc` = 0; `cause` = 0.
  - State = IDLE.
  - Reset is asynchronous and takes effect mid-operation, including mid-HANDLER; any pending exception is lost.
- **Capture latency:** 1 cycle. The pending registers update on the edge after `handler_address` is valid.
- **Commit latency:** a head match in cycle N gives `flush`/`redirect_valid` high in cycle N+1, for exactly one cycle.
- Head match uses the registered pending number, so an exception captured in cycle N cannot commit before cycle N+1.
- **Exception arriving in the commit-match cycle:** it is dropped, because the flush squashes it; the handler address is not overwritten.
- **`eret` and exception in the same HANDLER cycle:** `eret` wins and the exception is dropped.
- `redirect_pc` holds its last value when `redirect_valid` is low.
- `epc` and `cause` hold until the next commit.

## Structure
- **Package `exc_pkg`:**
  - State enum: `EXC_IDLE`, `EXC_PENDING`, `EXC_HANDLER`.
  - Cause enum.
  - Handler-address constants: `VEC_ILLEGAL` = 0x02BC, `VEC_LS` = 0x02E4, `VEC_DIV0` = 0x030C, `VEC_ADDR` = 0x0334.
  - Function `vec_to_cause`.
- **Sub-module `inst_age_cmp`:** parameterised by `INST_W`; inputs a, b, head; output `a_older`. It is purely combinational and reused by the LSQ.

## Test plan
- **Single exception:** `handler_address` = 0x030C, inst 5; ROB head reaches 5 with pc 0x0040 → one cycle later `flush` = 1, `redirect_pc` = 0x030C, `epc` = 0x0040, `cause` = 2, `in_handler` = 1.
- **Older replaces younger:** head = 60; inst 62 (0x02E4) arrives, then inst 1 (0x02BC) → pending stays 62. Repeat with inst 61 → pending becomes 61, and the commit at head = 61 redirects to 0x02BC.
- **Wrap-around:** head = 63; exception at inst 0 then inst 63 → 63 is selected; `redirect_pc` = handler of inst 63.
- **Handler masking and return:** in HANDLER with `epc` = 0x0040, inject 0x0334 → ignored. `eret` → next cycle `redirect_pc` = 0x0044, `flush` = 1, state IDLE.
- **Boundaries:**
  - `handler_address` = 0x1234 → no state change.
  - `eret` in IDLE → no output.
  - Deassert `reset_n` mid-PENDING → all outputs 0 immediately; no flush after release.
